// File: rtl/psg_bus_registers.sv
// Bus interface and register file for the AY-3-8913-compatible PSG: decodes BDIR/BC1,
// latches the register address, stores R0..R13 and fans their fields out to the sound stages.
module psg_bus_registers #(
    parameter logic [3:0] CHIP_ADDR = 4'b0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        bdir,
    input  logic        bc1,
    input  logic [7:0]  data_in,
    output logic [7:0]  data_out,
    output logic        data_oe,
    output logic [11:0] tone_period_a,
    output logic [11:0] tone_period_b,
    output logic [11:0] tone_period_c,
    output logic [4:0]  noise_period,
    output logic [5:0]  mixer_n,
    output logic [4:0]  amp_a,
    output logic [4:0]  amp_b,
    output logic [4:0]  amp_c,
    output logic [15:0] envelope_period,
    output logic        envelope_continue,
    output logic        envelope_attack,
    output logic        envelope_alternate,
    output logic        envelope_hold,
    output logic        envelope_restart
);

    typedef enum logic [1:0] {
        BUS_INACTIVE = 2'b00,
        BUS_READ     = 2'b01,
        BUS_WRITE    = 2'b10,
        BUS_LATCH    = 2'b11
    } bus_mode_t;

    localparam logic [3:0] ENV_SHAPE_ADDR = 4'd13;

    bus_mode_t  m;
    bus_mode_t  m_q;
    logic [3:0] addr;
    logic       addr_valid;
    logic [7:0] regs [16];
    logic       write_commit;

    // Implemented width of each register; R14/R15 have no storage on the 8913.
    function automatic logic [7:0] reg_mask(input logic [3:0] a);
        case (a)
            4'd0, 4'd2, 4'd4, 4'd7, 4'd11, 4'd12: reg_mask = 8'hFF;
            4'd1, 4'd3, 4'd5, 4'd13:              reg_mask = 8'h0F;
            4'd6, 4'd8, 4'd9, 4'd10:              reg_mask = 8'h1F;
            default:                              reg_mask = 8'h00;
        endcase
    endfunction

    assign m = bus_mode_t'({bdir, bc1});

    // A write commits only on entry into write mode, so a long hold is a single write.
    assign write_commit = (m == BUS_WRITE) && (m_q != BUS_WRITE) && addr_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            m_q              <= BUS_INACTIVE;
            addr             <= 4'd0;
            addr_valid       <= 1'b1;
            data_out         <= 8'h00;
            data_oe          <= 1'b0;
            envelope_restart <= 1'b0;
            // NOTE: the whole file is cleared on reset because every field output must
            // read 0 afterwards; this keeps the array in flops rather than a RAM macro.
            for (int i = 0; i < 16; i++) begin
                regs[i] <= 8'h00;
            end
        end else begin
            m_q              <= m;
            data_oe          <= (m == BUS_READ);
            data_out         <= ((m == BUS_READ) && addr_valid) ? regs[addr] : 8'h00;
            envelope_restart <= write_commit && (addr == ENV_SHAPE_ADDR);
            if (m == BUS_LATCH) begin
                addr       <= data_in[3:0];
                addr_valid <= (data_in[7:4] == CHIP_ADDR);
            end
            // Masking on the way in means reads return unused bits as 0 for free.
            if (write_commit) begin
                regs[addr] <= data_in & reg_mask(addr);
            end
        end
    end

    assign tone_period_a      = {regs[1][3:0], regs[0]};
    assign tone_period_b      = {regs[3][3:0], regs[2]};
    assign tone_period_c      = {regs[5][3:0], regs[4]};
    assign noise_period       = regs[6][4:0];
    assign mixer_n            = regs[7][5:0];
    assign amp_a              = regs[8][4:0];
    assign amp_b              = regs[9][4:0];
    assign amp_c              = regs[10][4:0];
    assign envelope_period    = {regs[12], regs[11]};
    assign envelope_continue  = regs[13][3];
    assign envelope_attack    = regs[13][2];
    assign envelope_alternate = regs[13][1];
    assign envelope_hold      = regs[13][0];

endmodule

// File: tb/tb_psg_bus_registers.sv
// Directed self-checking bench for psg_bus_registers; inputs change and outputs are
// sampled on the falling edge, away from the active rising edge.
module tb_psg_bus_registers;

    logic        clk = 1'b0;
    logic        reset;
    logic        bdir;
    logic        bc1;
    logic [7:0]  data_in;
    logic [7:0]  data_out;
    logic        data_oe;
    logic [11:0] tone_period_a, tone_period_b, tone_period_c;
    logic [4:0]  noise_period;
    logic [5:0]  mixer_n;
    logic [4:0]  amp_a, amp_b, amp_c;
    logic [15:0] envelope_period;
    logic        envelope_continue, envelope_attack, envelope_alternate, envelope_hold;
    logic        envelope_restart;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    psg_bus_registers #(.CHIP_ADDR(4'b0000)) dut (
        .clk                (clk),
        .reset              (reset),
        .bdir               (bdir),
        .bc1                (bc1),
        .data_in            (data_in),
        .data_out           (data_out),
        .data_oe            (data_oe),
        .tone_period_a      (tone_period_a),
        .tone_period_b      (tone_period_b),
        .tone_period_c      (tone_period_c),
        .noise_period       (noise_period),
        .mixer_n            (mixer_n),
        .amp_a              (amp_a),
        .amp_b              (amp_b),
        .amp_c              (amp_c),
        .envelope_period    (envelope_period),
        .envelope_continue  (envelope_continue),
        .envelope_attack    (envelope_attack),
        .envelope_alternate (envelope_alternate),
        .envelope_hold      (envelope_hold),
        .envelope_restart   (envelope_restart)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Wait for the falling edge, then drive the bus mode and data for the next rising edge.
    task automatic set_bus(input logic [1:0] mode, input logic [7:0] d);
        @(negedge clk);
        {bdir, bc1} = mode;
        data_in     = d;
    endtask

    task automatic latch(input logic [7:0] a);
        set_bus(2'b11, a);
    endtask

    task automatic write(input logic [7:0] d);
        set_bus(2'b10, d);
        set_bus(2'b00, 8'h00);
    endtask

    task automatic read(output logic [7:0] d, output logic oe);
        set_bus(2'b01, 8'h00);
        @(negedge clk);
        d  = data_out;
        oe = data_oe;
        {bdir, bc1} = 2'b00;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".data_out"}, data_out, 0);
        check({tag, ".data_oe"}, data_oe, 0);
        check({tag, ".restart"}, envelope_restart, 0);
        check({tag, ".tones"}, {tone_period_a, tone_period_b, tone_period_c}, 0);
        check({tag, ".noise_mixer"}, {noise_period, mixer_n}, 0);
        check({tag, ".amps"}, {amp_a, amp_b, amp_c}, 0);
        check({tag, ".env_period"}, envelope_period, 0);
        check({tag, ".shape"}, {envelope_continue, envelope_attack,
                                envelope_alternate, envelope_hold}, 0);
    endtask

    logic [7:0] rd;
    logic       oe;
    int         pulses;
    logic [1:0] seq_mode [5];
    logic [4:0] seq_exp;

    initial begin
        reset = 1'b1;
        {bdir, bc1} = 2'b00;
        data_in = 8'h00;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;

        // 1: tone period A via R1/R0, then read R1 back with one-cycle latency.
        latch(8'h01); write(8'hFF);
        latch(8'h00); write(8'h34);
        check("t1.tone_a", tone_period_a, 12'hF34);
        latch(8'h01);
        read(rd, oe);
        check("t1.read_r1", rd, 8'h0F);
        check("t1.read_oe", oe, 1'b1);
        @(negedge clk);
        check("t1.idle_oe", data_oe, 1'b0);
        check("t1.idle_data", data_out, 8'h00);

        // 2: held write to R13 gives exactly one restart pulse.
        latch(8'h0D);
        set_bus(2'b10, 8'h0A);
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 0) check("t2.pulse_first", envelope_restart, 1'b1);
            if (envelope_restart) pulses++;
            if (i == 4) {bdir, bc1} = 2'b00;
        end
        check("t2.pulse_count", pulses, 1);
        check("t2.shape", {envelope_continue, envelope_attack,
                           envelope_alternate, envelope_hold}, 4'b1010);

        // 3: wrong chip nibble deselects: write ignored, read returns 0.
        latch(8'h18); write(8'h55);
        check("t3.amp_a", amp_a, 5'h00);
        check("t3.tone_a", tone_period_a, 12'hF34);
        read(rd, oe);
        check("t3.read", rd, 8'h00);
        check("t3.read_oe", oe, 1'b1);

        // 4: width masking, plus R14 which has no storage.
        latch(8'h08); write(8'hFF);
        check("t4.amp_a", amp_a, 5'h1F);
        read(rd, oe);
        check("t4.read_r8", rd, 8'h1F);
        latch(8'h06); write(8'hFF);
        check("t4.noise", noise_period, 5'h1F);
        latch(8'h07); write(8'hFF);
        check("t4.mixer", mixer_n, 6'h3F);
        read(rd, oe);
        check("t4.read_r7", rd, 8'hFF);
        latch(8'h0E); write(8'hAA);
        read(rd, oe);
        check("t4.read_r14", rd, 8'h00);

        // 5: envelope period, then reset during a held write.
        latch(8'h0B); write(8'h34);
        latch(8'h0C); write(8'h12);
        check("t5.env_period", envelope_period, 16'h1234);
        latch(8'h0D);
        set_bus(2'b10, 8'h05);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_all_zero("t5.reset");
        reset = 1'b0;
        // Write mode still held: first edge out of reset commits to R0 (addr 0, valid).
        @(negedge clk);
        check("t5.post_reset_tone_a", tone_period_a, 12'h005);
        check("t5.post_reset_restart", envelope_restart, 1'b0);
        {bdir, bc1} = 2'b00;

        // 6: identical R13 writes separated by an idle cycle each pulse.
        latch(8'h0D);
        seq_mode = '{2'b10, 2'b00, 2'b10, 2'b00, 2'b00};
        seq_exp  = 5'b00101;   // bit i = expected restart sampled after step i
        @(negedge clk);
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            {bdir, bc1} = seq_mode[i];
            data_in = 8'h0E;
            @(negedge clk);
            check($sformatf("t6.restart_step%0d", i), envelope_restart, seq_exp[i]);
            if (envelope_restart) pulses++;
        end
        check("t6.pulse_count", pulses, 2);
        check("t6.shape", {envelope_continue, envelope_attack,
                           envelope_alternate, envelope_hold}, 4'b1110);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish, expected finish before 100000");
        $fatal(1, "bench timeout");
    end

endmodule
